// File: rtl/uc_pkg.sv
// Shared microcontroller sequencer definitions: opcode map, unit indices and
// the sequencer state encoding.
package uc_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MEM_LO = 4'h1;
    localparam logic [3:0] OP_MEM_HI = 4'h3;
    localparam logic [3:0] OP_BR_LO  = 4'h4;
    localparam logic [3:0] OP_BR_HI  = 4'h7;
    localparam logic [3:0] OP_ALU_LO = 4'h8;
    localparam logic [3:0] OP_ALU_HI = 4'hE;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam int unsigned NUM_UNITS = 3;
    localparam logic [1:0] UNIT_ALU = 2'd0;
    localparam logic [1:0] UNIT_MEM = 2'd1;
    localparam logic [1:0] UNIT_BR  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_WAIT,
        S_HALTED,
        S_FAULT
    } seq_state_t;

    // Only meaningful for opcodes other than NOP/HALT.
    function automatic logic [1:0] unit_of(input logic [3:0] op);
        if (op >= OP_MEM_LO && op <= OP_MEM_HI)
            return UNIT_MEM;
        else if (op >= OP_BR_LO && op <= OP_BR_HI)
            return UNIT_BR;
        else if (op >= OP_ALU_LO && op <= OP_ALU_HI)
            return UNIT_ALU;
        else
            return UNIT_ALU;
    endfunction

    function automatic logic [NUM_UNITS-1:0] unit_mask(input logic [1:0] u);
        return NUM_UNITS'(1) << u;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-memory fetch port and execution-unit handshake of the sequencer.
interface instr_sequencer_if;
    import uc_pkg::*;

    logic [15:0]          mem_data;
    logic                 mem_valid;
    logic                 mem_rd;
    logic [15:0]          ir;
    logic [NUM_UNITS-1:0] unit_start;
    logic [NUM_UNITS-1:0] unit_done;

    modport master (
        input  mem_data, mem_valid, unit_done,
        output mem_rd, ir, unit_start
    );

    modport slave (
        output mem_data, mem_valid, unit_done,
        input  mem_rd, ir, unit_start
    );

endinterface

// File: rtl/seq_watchdog.sv
// Dispatch watchdog: counts WAIT cycles and flags the cycle in which the
// TIMEOUT-th WAIT cycle completes without a done.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != '1)
            count <= count + 8'd1;
    end

    // count holds completed WAIT cycles; the edge ending this cycle reaches TIMEOUT.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetch, decode, dispatch to one execution unit and
// wait for its done under watchdog supervision; halt and fault are terminal.
module instr_sequencer
    import uc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    instr_sequencer_if.master  bus,
    output logic               pc_inc,
    output logic               halted,
    output logic               fault,
    output logic               busy
);

    seq_state_t           state_q, state_d;
    logic [1:0]           unit_q, unit_d;
    logic [15:0]          ir_q;
    logic                 mem_rd_q;
    logic                 expired;
    logic [NUM_UNITS-1:0] mask;
    logic [NUM_UNITS-1:0] unit_start;
    logic                 done_ok;
    logic                 done_bad;
    logic [3:0]           opcode;

    assign opcode   = ir_q[15:12];
    assign mask     = unit_mask(unit_q);
    assign done_ok  = |(bus.unit_done & mask);
    assign done_bad = |(bus.unit_done & ~mask);

    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == S_DISPATCH),
        .enable  (state_q == S_WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            unit_q   <= UNIT_ALU;
            ir_q     <= '0;
            mem_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            unit_q   <= unit_d;
            if (state_q == S_FETCH && run && bus.mem_valid)
                ir_q <= bus.mem_data;
            // Registered so that run has no combinational path to mem_rd.
            mem_rd_q <= (state_d == S_FETCH) && run;
        end
    end

    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        pc_inc     = 1'b0;
        unit_start = '0;
        busy       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (run && bus.mem_valid)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    pc_inc  = 1'b1;
                    state_d = S_FETCH;
                end else if (opcode == OP_HALT) begin
                    state_d = S_HALTED;
                end else begin
                    unit_d  = unit_of(opcode);
                    state_d = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                unit_start = mask;
                busy       = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                // A stray done faults even alongside the correct one; the
                // correct done beats a simultaneous watchdog expiry.
                if (done_bad)
                    state_d = S_FAULT;
                else if (done_ok)
                    state_d = S_FETCH;
                else if (expired)
                    state_d = S_FAULT;
            end
            S_HALTED: halted = 1'b1;
            S_FAULT:  fault  = 1'b1;
            default:  state_d = S_IDLE;
        endcase
    end

    assign bus.ir         = ir_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.unit_start = unit_start;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each fetched word queues its expected
// dispatch/NOP event, which a negedge monitor pops and compares.
module tb_instr_sequencer;

    logic clk;
    logic rst;
    logic run;
    logic pc_inc, halted, fault, busy;

    instr_sequencer_if bus ();

    instr_sequencer #(.TIMEOUT(31)) dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .bus    (bus),
        .pc_inc (pc_inc),
        .halted (halted),
        .fault  (fault),
        .busy   (busy)
    );

    int checks = 0;
    int errors = 0;
    int pc_cnt = 0;
    logic [19:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event = {pc_inc, unit_start, ir}
    always @(negedge clk) begin
        if (!rst && (pc_inc || (bus.unit_start != 3'b000))) begin
            if (pc_inc)
                pc_cnt++;
            if (exp_q.size() == 0)
                check("sb_extra", exp_q.size(), 1);
            else
                check("sb_event", {pc_inc, bus.unit_start, bus.ir}, exp_q.pop_front());
        end
    end

    task automatic push_expected(input logic [15:0] w);
        logic [3:0] op;
        op = w[15:12];
        if (op == 4'h0)
            exp_q.push_back({4'b1000, w});
        else if (op >= 4'h1 && op <= 4'h3)
            exp_q.push_back({4'b0010, w});
        else if (op >= 4'h4 && op <= 4'h7)
            exp_q.push_back({4'b0100, w});
        else if (op != 4'hF)
            exp_q.push_back({4'b0001, w});
    endtask

    // Called at a negedge; returns at the negedge of the DECODE cycle.
    task automatic feed(input logic [15:0] w);
        int n;
        n = 0;
        while (!bus.mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_rd", bus.mem_rd, 1);
        push_expected(w);
        bus.mem_data  = w;
        bus.mem_valid = 1'b1;
        @(negedge clk);
        bus.mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        bus.mem_valid = 1'b0;
        bus.unit_done = 3'b000;
        @(negedge clk);
        check("rst_vals", {bus.ir, bus.mem_rd, bus.unit_start, pc_inc, halted, fault, busy}, 0);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int wait_cnt;
        int start_seen;
        logic any_rd;
        rst = 1'b1;
        run = 1'b1;
        bus.mem_data  = '0;
        bus.mem_valid = 1'b0;
        bus.unit_done = 3'b000;

        // ALU dispatch, done 9 cycles after start
        do_reset();
        @(negedge clk);
        check("first_rd", bus.mem_rd, 1);
        feed(16'h8041);
        check("t1_decode_busy", busy, 0);
        @(negedge clk);
        check("t1_start", bus.unit_start, 3'b001);
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1)
                check("t1_start_once", bus.unit_start, 3'b000);
            if (busy) busy_cnt++;
        end
        @(negedge clk);
        if (busy) busy_cnt++;
        bus.unit_done = 3'b001;
        @(negedge clk);
        bus.unit_done = 3'b000;
        check("t1_busy_len", busy_cnt, 10);
        check("t1_busy_end", busy, 0);
        check("t1_rd_after", bus.mem_rd, 1);
        check("t1_fault", fault, 0);

        // NOP, NOP, HALT
        pc_cnt = 0;
        feed(16'h0000);
        feed(16'h0000);
        feed(16'hF000);
        @(negedge clk);
        check("t2_halted", halted, 1);
        check("t2_pc_cnt", pc_cnt, 2);
        bus.mem_valid = 1'b1;
        any_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_rd |= bus.mem_rd;
        end
        bus.mem_valid = 1'b0;
        check("t2_rd_low", any_rd, 0);
        check("t2_still_halted", {halted, fault}, 2'b10);

        // Memory op with no done: fault after 31 WAIT cycles
        do_reset();
        feed(16'h2005);
        @(negedge clk);
        check("t3_start", bus.unit_start, 3'b010);
        wait_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fault) break;
            if (busy) wait_cnt++;
        end
        check("t3_fault", fault, 1);
        check("t3_wait_len", wait_cnt, 31);
        check("t3_halted", halted, 0);

        // Same, done on WAIT cycle 31 beats the watchdog
        do_reset();
        feed(16'h2005);
        @(negedge clk);
        check("t3b_start", bus.unit_start, 3'b010);
        for (int i = 0; i < 30; i++) @(negedge clk);
        @(negedge clk);
        bus.unit_done = 3'b010;
        @(negedge clk);
        bus.unit_done = 3'b000;
        check("t3b_fault", fault, 0);
        check("t3b_busy", busy, 0);
        check("t3b_rd", bus.mem_rd, 1);

        // Branch op receives ALU done: spurious -> fault
        feed(16'h5000);
        @(negedge clk);
        check("t4_start", bus.unit_start, 3'b100);
        @(negedge clk);
        bus.unit_done = 3'b001;
        @(negedge clk);
        bus.unit_done = 3'b000;
        check("t4_status", {halted, fault, busy}, 3'b010);

        // Asynchronous reset mid-WAIT
        do_reset();
        feed(16'h9123);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t5_in_wait", busy, 1);
        rst = 1'b1;
        #1;
        check("t5_async", {bus.ir, bus.mem_rd, bus.unit_start, pc_inc, halted, fault, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rd_restart", bus.mem_rd, 1);
        check("t5_ir_zero", bus.ir, 0);

        // run low with valid data, plus done outside WAIT
        run = 1'b0;
        bus.mem_data  = 16'h1234;
        bus.mem_valid = 1'b1;
        bus.unit_done = 3'b111;
        @(negedge clk);
        bus.unit_done = 3'b000;
        any_rd = 1'b0;
        start_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_rd |= bus.mem_rd;
            if (busy) start_seen++;
        end
        check("t6_no_rd", any_rd, 0);
        check("t6_ir_held", bus.ir, 0);
        check("t6_no_busy", start_seen, 0);
        check("t6_done_ignored", fault, 0);
        bus.mem_valid = 1'b0;
        run = 1'b1;
        @(negedge clk);

        // Drop run during WAIT: instruction completes, no further fetch
        feed(16'h3ABC);
        @(negedge clk);
        check("t6b_start", bus.unit_start, 3'b010);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.unit_done = 3'b010;
        @(negedge clk);
        bus.unit_done = 3'b000;
        check("t6b_done", {busy, fault}, 2'b00);
        check("t6b_rd_low", bus.mem_rd, 0);
        bus.mem_data  = 16'h7777;
        bus.mem_valid = 1'b1;
        any_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            any_rd |= bus.mem_rd;
        end
        bus.mem_valid = 1'b0;
        check("t6b_no_fetch", any_rd, 0);
        check("t6b_ir_kept", bus.ir, 16'h3ABC);

        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
